// File: rtl/multicycle_control_unit.sv
// Multi-cycle control sequencer for the RV32I subset (R, I-ALU, load, store, branch).
// Handshakes with variable-latency instruction/data memories and traps on bus timeout.
module multicycle_control_unit #(
    parameter int WAIT_TIMEOUT = 15,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           opcode,
    input  logic                 ALU_zero_flag,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic                 imem_req,
    output logic                 ir_w,
    output logic                 pc_w,
    output logic                 pc_branch,
    output logic [1:0]           ctrl_ALU_op,
    output logic                 ctrl_ALU_src,
    output logic                 ctrl_reg_w,
    output logic                 ctrl_mem_r,
    output logic                 ctrl_mem_w,
    output logic                 ctrl_mem_to_reg,
    output logic                 illegal_instr,
    output logic                 bus_error,
    output logic [CNT_WIDTH-1:0] instret_count,
    output logic [2:0]           state_dbg
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEM       = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    typedef enum logic [2:0] {C_R, C_I, C_LD, C_ST, C_BR} iclass_t;

    localparam int WCW = (WAIT_TIMEOUT < 2) ? 1 : $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WCW-1:0] WAIT_MAX = WCW'(WAIT_TIMEOUT);

    state_t          state, state_nxt;
    iclass_t         cls, cls_dec;
    logic            dec_legal;
    logic [WCW-1:0]  wait_cnt;
    logic            waiting, timeout, retire;

    always_comb begin
        dec_legal = 1'b1;
        cls_dec   = C_R;
        case (opcode)
            7'b0110011: cls_dec = C_R;
            7'b0010011: cls_dec = C_I;
            7'b0000011: cls_dec = C_LD;
            7'b0100011: cls_dec = C_ST;
            7'b1100011: cls_dec = C_BR;
            default:    dec_legal = 1'b0;
        endcase
    end

    // Ready wins over an expiring counter: timeout only fires while still waiting.
    assign waiting = (state == S_FETCH && !imem_ready) || (state == S_MEM && !dmem_ready);
    assign timeout = (WAIT_TIMEOUT != 0) && waiting && (wait_cnt == WAIT_MAX);

    always_comb begin
        state_nxt       = state;
        retire          = 1'b0;
        imem_req        = 1'b0;
        ir_w            = 1'b0;
        pc_w            = 1'b0;
        pc_branch       = 1'b0;
        ctrl_ALU_op     = 2'b00;
        ctrl_ALU_src    = 1'b0;
        ctrl_reg_w      = 1'b0;
        ctrl_mem_r      = 1'b0;
        ctrl_mem_w      = 1'b0;
        ctrl_mem_to_reg = 1'b0;
        case (state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_w      = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timeout) begin
                    state_nxt = S_HALT;
                end
            end
            S_DECODE: begin
                if (dec_legal) begin
                    state_nxt = S_EXECUTE;
                end else begin
                    pc_w      = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_EXECUTE: begin
                case (cls)
                    C_R: begin
                        ctrl_ALU_op = 2'b10;
                        state_nxt   = S_WRITEBACK;
                    end
                    C_I: begin
                        ctrl_ALU_op  = 2'b10;
                        ctrl_ALU_src = 1'b1;
                        state_nxt    = S_WRITEBACK;
                    end
                    C_LD, C_ST: begin
                        ctrl_ALU_src = 1'b1;
                        state_nxt    = S_MEM;
                    end
                    C_BR: begin
                        ctrl_ALU_op = 2'b01;
                        pc_w        = 1'b1;
                        pc_branch   = ALU_zero_flag;
                        retire      = 1'b1;
                        state_nxt   = S_FETCH;
                    end
                    default: state_nxt = S_FETCH;
                endcase
            end
            S_MEM: begin
                ctrl_ALU_src = 1'b1;
                ctrl_mem_r   = (cls == C_LD);
                ctrl_mem_w   = (cls == C_ST);
                if (dmem_ready) begin
                    if (cls == C_ST) begin
                        pc_w      = 1'b1;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WRITEBACK;
                    end
                end else if (timeout) begin
                    state_nxt = S_HALT;
                end
            end
            S_WRITEBACK: begin
                ctrl_reg_w      = 1'b1;
                pc_w            = 1'b1;
                retire          = 1'b1;
                ctrl_mem_to_reg = (cls == C_LD);
                if (cls == C_R || cls == C_I) ctrl_ALU_op = 2'b10;
                ctrl_ALU_src    = (cls == C_I);
                state_nxt       = S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
        // Strobes must drop the instant reset asserts, not at the next edge.
        if (rst) begin
            imem_req        = 1'b0;
            ir_w            = 1'b0;
            pc_w            = 1'b0;
            pc_branch       = 1'b0;
            ctrl_ALU_op     = 2'b00;
            ctrl_ALU_src    = 1'b0;
            ctrl_reg_w      = 1'b0;
            ctrl_mem_r      = 1'b0;
            ctrl_mem_w      = 1'b0;
            ctrl_mem_to_reg = 1'b0;
            retire          = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_FETCH;
            cls           <= C_R;
            wait_cnt      <= '0;
            illegal_instr <= 1'b0;
            bus_error     <= 1'b0;
            instret_count <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_DECODE && dec_legal) cls <= cls_dec;
            if (state == S_DECODE && !dec_legal) illegal_instr <= 1'b1;
            if (timeout) bus_error <= 1'b1;
            if (retire) instret_count <= instret_count + CNT_WIDTH'(1);
            if (state_nxt != state || !waiting) wait_cnt <= '0;
            else if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + WCW'(1);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction behavioural model drives random
// handshakes and publishes expected outputs; a negedge process compares every cycle.
module tb_multicycle_control_unit;

    localparam int WT = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        ALU_zero_flag, imem_ready, dmem_ready;
    logic        imem_req, ir_w, pc_w, pc_branch;
    logic [1:0]  ctrl_ALU_op;
    logic        ctrl_ALU_src, ctrl_reg_w, ctrl_mem_r, ctrl_mem_w, ctrl_mem_to_reg;
    logic        illegal_instr, bus_error;
    logic [31:0] instret_count;
    logic [2:0]  state_dbg;

    multicycle_control_unit #(.WAIT_TIMEOUT(WT), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .ALU_zero_flag(ALU_zero_flag),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
        .ir_w(ir_w), .pc_w(pc_w), .pc_branch(pc_branch), .ctrl_ALU_op(ctrl_ALU_op),
        .ctrl_ALU_src(ctrl_ALU_src), .ctrl_reg_w(ctrl_reg_w), .ctrl_mem_r(ctrl_mem_r),
        .ctrl_mem_w(ctrl_mem_w), .ctrl_mem_to_reg(ctrl_mem_to_reg),
        .illegal_instr(illegal_instr), .bus_error(bus_error),
        .instret_count(instret_count), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  st;
        logic        imem_req, ir_w, pc_w, pc_branch;
        logic [1:0]  alu_op;
        logic        alu_src, reg_w, mem_r, mem_w, mem_to_reg, illegal, bus_err;
        logic [31:0] instret;
    } obs_t;

    obs_t        e, act;
    logic        chk_en = 1'b0;
    int          checks = 0, errors = 0;
    logic [31:0] m_instret;
    logic        m_illegal, m_buserr, m_halt;

    assign act = {state_dbg, imem_req, ir_w, pc_w, pc_branch, ctrl_ALU_op, ctrl_ALU_src,
                  ctrl_reg_w, ctrl_mem_r, ctrl_mem_w, ctrl_mem_to_reg, illegal_instr,
                  bus_error, instret_count};

    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL cycle t=%0t outputs got %h want %h", $time, act, e);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, a, x);
        end
    endtask

    function automatic obs_t base(input logic [2:0] st);
        obs_t o;
        o         = '0;
        o.st      = st;
        o.illegal = m_illegal;
        o.bus_err = m_buserr;
        o.instret = m_instret;
        return o;
    endfunction

    // 0 R, 1 I, 2 LD, 3 ST, 4 BR, -1 unknown
    function automatic int classify(input logic [6:0] op);
        case (op)
            7'b0110011: return 0;
            7'b0010011: return 1;
            7'b0000011: return 2;
            7'b0100011: return 3;
            7'b1100011: return 4;
            default:    return -1;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_instret = '0;
        m_illegal = 1'b0;
        m_buserr  = 1'b0;
        m_halt    = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        e          = base(3'd0);
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            e             = base(3'd5);
            imem_ready    = 1'($urandom);
            dmem_ready    = 1'($urandom);
            opcode        = 7'($urandom);
            ALU_zero_flag = 1'($urandom);
            tick();
        end
    endtask

    // iw/dw: not-ready cycles before ready in FETCH/MEM; rst_at: MEM cycle to reset in (-1 none)
    task automatic run_instr(input logic [6:0] op, input logic zero, input int iw,
                             input int dw, input int rst_at);
        int   c;
        logic rdy;
        c = classify(op);
        for (int k = 0; k < 64; k++) begin
            rdy           = (k >= iw);
            imem_ready    = rdy;
            dmem_ready    = 1'($urandom);
            opcode        = 7'($urandom);
            ALU_zero_flag = 1'($urandom);
            e             = base(3'd0);
            e.imem_req    = 1'b1;
            e.ir_w        = rdy;
            tick();
            if (rdy) break;
            if (k == WT) begin
                m_buserr = 1'b1;
                m_halt   = 1'b1;
                return;
            end
        end
        opcode     = op;
        imem_ready = 1'($urandom);
        dmem_ready = 1'($urandom);
        e          = base(3'd1);
        if (c < 0) begin
            e.pc_w = 1'b1;
            tick();
            m_illegal = 1'b1;
            return;
        end
        tick();
        ALU_zero_flag = zero;
        e = base(3'd2);
        case (c)
            0: e.alu_op = 2'b10;
            1: begin e.alu_op = 2'b10; e.alu_src = 1'b1; end
            2, 3: e.alu_src = 1'b1;
            default: begin
                e.alu_op    = 2'b01;
                e.pc_w      = 1'b1;
                e.pc_branch = zero;
            end
        endcase
        tick();
        ALU_zero_flag = 1'($urandom);
        if (c == 4) begin
            m_instret++;
            return;
        end
        if (c == 2 || c == 3) begin
            for (int k = 0; k < 64; k++) begin
                rdy        = (k >= dw);
                dmem_ready = rdy;
                imem_ready = 1'($urandom);
                e          = base(3'd3);
                e.alu_src  = 1'b1;
                e.mem_r    = (c == 2);
                e.mem_w    = (c == 3);
                e.pc_w     = (c == 3) && rdy;
                if (k == rst_at) begin
                    #1;
                    chk("mem_w_before_rst", 32'(ctrl_mem_w), 32'(c == 3));
                    #1;
                    rst = 1'b1;
                    #1;
                    chk("mem_w_in_rst", 32'(ctrl_mem_w), 32'd0);
                    chk("mem_r_in_rst", 32'(ctrl_mem_r), 32'd0);
                    chk("instret_in_rst", instret_count, 32'd0);
                    model_reset();
                    e = base(3'd0);
                    tick();
                    rst = 1'b0;
                    return;
                end
                tick();
                if (rdy) break;
                if (k == WT) begin
                    m_buserr = 1'b1;
                    m_halt   = 1'b1;
                    return;
                end
            end
            if (c == 3) begin
                m_instret++;
                return;
            end
        end
        dmem_ready   = 1'($urandom);
        imem_ready   = 1'($urandom);
        e            = base(3'd4);
        e.reg_w      = 1'b1;
        e.pc_w       = 1'b1;
        e.mem_to_reg = (c == 2);
        e.alu_op     = (c <= 1) ? 2'b10 : 2'b00;
        e.alu_src    = (c == 1);
        tick();
        m_instret++;
    endtask

    logic [6:0] ops [0:4];

    initial begin
        ops[0] = 7'b0110011; ops[1] = 7'b0010011; ops[2] = 7'b0000011;
        ops[3] = 7'b0100011; ops[4] = 7'b1100011;
        opcode = '0; ALU_zero_flag = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        rst = 1'b1;
        model_reset();
        e = base(3'd0);
        chk_en = 1'b1;
        do_reset();
        chk("reset_state", 32'(state_dbg), 32'd0);
        chk("reset_instret", instret_count, 32'd0);

        run_instr(7'b0110011, 1'b0, 0, 0, -1);
        chk("rtype_instret", instret_count, 32'd1);
        run_instr(7'b0000011, 1'b0, 0, 2, -1);
        run_instr(7'b1100011, 1'b1, 0, 0, -1);
        run_instr(7'b1100011, 1'b0, 0, 0, -1);
        run_instr(7'b0100011, 1'b0, 0, 0, -1);
        chk("mix_instret", instret_count, 32'd5);

        run_instr(7'b1111111, 1'b0, 1, 0, -1);
        chk("illegal_flag", 32'(illegal_instr), 32'd1);
        chk("illegal_noretire", instret_count, 32'd5);
        run_instr(7'b0110011, 1'b0, 2, 0, -1);
        chk("illegal_sticky", 32'(illegal_instr), 32'd1);
        chk("after_illegal_instret", instret_count, 32'd6);

        run_instr(7'b0010011, 1'b0, 15, 0, -1);
        chk("ready_on_last_wait", 32'(bus_error), 32'd0);
        run_instr(7'b0110011, 1'b0, 16, 0, -1);
        chk("fetch_timeout_state", 32'(state_dbg), 32'd5);
        chk("fetch_timeout_err", 32'(bus_error), 32'd1);
        halt_cycles(4);
        do_reset();

        run_instr(7'b0000011, 1'b0, 0, 16, -1);
        chk("mem_timeout_state", 32'(state_dbg), 32'd5);
        halt_cycles(3);
        do_reset();

        run_instr(7'b0110011, 1'b0, 0, 0, -1);
        run_instr(7'b0100011, 1'b0, 0, 5, 2);
        chk("fetch_after_rst", 32'(state_dbg), 32'd0);
        chk("instret_after_rst", instret_count, 32'd0);

        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 4)];
            run_instr(op, 1'($urandom), ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3),
                      ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3), -1);
        end
        chk("random_no_bus_error", 32'(bus_error), 32'd0);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
